alu_clock_counter: RTL and testbench
====================================

Name: alu_clock_counter

Overview:
Timing-and-arithmetic core of the 8-bit CPU. It combines four functions:
- the program counter (increment/jump-load);
- the micro-step counter that sequences the decoder (cleared by NEXT);
- a run/halt control that freezes both counters;
- the combinational 8-bit ALU that feeds the sum buffer onto the bus.
Everything is on a single clock domain.

Parameters:
DATA_WIDTH, 8, ALU operand/result width
PC_WIDTH, 8, program counter width (also width of pc_in)
STEP_WIDTH, 4, micro-step counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
halt  input  1  HALT control; stops the core on the sampling edge
pc_inc  input  1  CI: increment program counter
pc_load  input  1  J: load program counter from pc_in
pc_in  input  PC_WIDTH  jump target (bus value)
pc_out  output  PC_WIDTH  program counter value
step_next  input  1  NEXT: clear micro-step counter
step  output  STEP_WIDTH  current micro-step (cycle)
running  output  1  1 = core running, 0 = halted
alu_a  input  DATA_WIDTH  operand A (register A)
alu_b  input  DATA_WIDTH  operand B (register B)
alu_cin  input  1  carry in (add mode only)
alu_sub  input  1  0 = add, 1 = subtract
alu_sum  output  DATA_WIDTH  result
alu_cout  output  1  carry out / no-borrow
alu_zero  output  1  alu_sum == 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset). All outputs are registered except the ALU outputs.
- Reset (reset==0 at rising edge): pc_out=0, step=0, running=1. Reset has highest priority and also clears a halted state.
- Halt:
  - If running==1 and halt==1 at an edge, running becomes 0 on that edge; pc_out and step hold (no update on that edge).
  - While running==0, pc_out and step hold regardless of pc_inc, pc_load or step_next.
  - Only reset restarts the core. halt is ignored while already halted.
- Program counter (per edge, while running and not halting):
  - pc_load=1: pc_out <= pc_in.
  - else pc_inc=1: pc_out <= pc_out+1, wrapping 255 -> 0.
  - else hold.
  - pc_load has priority over pc_inc when both are high (jump overrides increment).
- Micro-step counter (per edge, while running and not halting):
  - step_next=1: step <= 0.
  - else step <= step+1, wrapping 15 -> 0.
  - It free-runs every cycle; NEXT is the only clear besides reset.
- ALU: purely combinational, zero latency, unaffected by reset/halt/running.
  - add: {alu_cout, alu_sum} = alu_a + alu_b + alu_cin, computed at 9-bit width.
  - sub: {alu_cout, alu_sum} = alu_a + ~alu_b + 1; alu_cin is ignored. alu_cout=1 means no borrow (alu_a >= alu_b).
  - alu_zero = (alu_sum == 0).
  - Output is never X for known inputs.
- Simultaneous events:
  - reset beats halt beats counter updates.
  - pc_load and step_next in the same cycle both take effect.
- Reset mid-operation: all state returns to reset values on that edge, irrespective of other inputs.

Test Plan:
- Reset then run 5 cycles with pc_inc=1, step_next=0, halt=0 -> pc_out 0,1,2,3,4,5 and step 0..5; running=1 throughout.
- Preset pc_out=254 via pc_load/pc_in=8'hFE, then pc_inc for 3 cycles -> FE, FF, 00, 01. Let step run 17 cycles from 0 -> 15 then 0, 1 (wrap).
- pc_in=8'h3C with pc_load=1 and pc_inc=1 in the same cycle -> pc_out=3C. step_next=1 at step=3 -> step=0 next edge, counting resumes 1, 2.
- halt=1 for one edge at pc_out=7, step=2 -> running=0, pc_out stays 7 and step stays 2 for 10 further cycles despite pc_inc/step_next. reset=0 for one edge -> pc_out=0, step=0, running=1.
- ALU add: 8'h0F+8'h01+0 -> sum 10, cout 0, zero 0. 8'hFF+8'h01+0 -> sum 00, cout 1, zero 1. 8'hFF+8'h00+1 -> sum 00, cout 1.
- ALU sub: 8'h05-8'h03 -> sum 02, cout 1. 8'h03-8'h05 -> sum FE, cout 0. 8'h42-8'h42 -> sum 00, zero 1, cout 1. alu_cin=1 does not change any sub result.

Source files
------------

// File: rtl/alu_clock_counter.sv
// Timing-and-arithmetic core of the 8-bit CPU: program counter, micro-step
// counter, run/halt control and the combinational ALU feeding the sum buffer.
module alu_clock_counter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  pc_inc,
    input  logic                  pc_load,
    input  logic [PC_WIDTH-1:0]   pc_in,
    output logic [PC_WIDTH-1:0]   pc_out,
    input  logic                  step_next,
    output logic [STEP_WIDTH-1:0] step,
    output logic                  running,
    input  logic [DATA_WIDTH-1:0] alu_a,
    input  logic [DATA_WIDTH-1:0] alu_b,
    input  logic                  alu_cin,
    input  logic                  alu_sub,
    output logic [DATA_WIDTH-1:0] alu_sum,
    output logic                  alu_cout,
    output logic                  alu_zero
);

    localparam int unsigned RES_W = DATA_WIDTH + 1;

    logic [PC_WIDTH-1:0]   pc_q,      pc_d;
    logic [STEP_WIDTH-1:0] step_q,    step_d;
    logic                  running_q, running_d;

    // Next state: a halting edge freezes both counters along with dropping running.
    always_comb begin
        pc_d      = pc_q;
        step_d    = step_q;
        running_d = running_q;
        if (running_q) begin
            if (halt) begin
                running_d = 1'b0;
            end else begin
                if (pc_load) begin
                    pc_d = pc_in;
                end else if (pc_inc) begin
                    pc_d = pc_q + PC_WIDTH'(1);
                end
                step_d = step_next ? '0 : step_q + STEP_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q      <= '0;
            step_q    <= '0;
            running_q <= 1'b1;
        end else begin
            pc_q      <= pc_d;
            step_q    <= step_d;
            running_q <= running_d;
        end
    end

    assign pc_out  = pc_q;
    assign step    = step_q;
    assign running = running_q;

    // Subtract is a + ~b + 1, so cout reads as "no borrow" in that mode.
    logic [DATA_WIDTH-1:0] alu_b_op;
    logic                  alu_carry;
    logic [RES_W-1:0]      alu_res;

    always_comb begin
        alu_b_op  = alu_sub ? ~alu_b : alu_b;
        alu_carry = alu_sub ? 1'b1 : alu_cin;
        alu_res   = RES_W'(alu_a) + RES_W'(alu_b_op) + RES_W'(alu_carry);
    end

    assign alu_sum  = alu_res[DATA_WIDTH-1:0];
    assign alu_cout = alu_res[DATA_WIDTH];
    assign alu_zero = (alu_res[DATA_WIDTH-1:0] == '0);

endmodule

// File: tb/tb_alu_clock_counter.sv
// Self-checking bench for alu_clock_counter: expected results are queued when
// stimulus is applied and popped when the DUT output is sampled.
module tb_alu_clock_counter;

    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] step;
        logic       run;
    } ctr_exp_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       zero;
    } alu_exp_t;

    logic       clk = 1'b0;
    logic       reset, halt, pc_inc, pc_load, step_next;
    logic [7:0] pc_in, pc_out;
    logic [3:0] step;
    logic       running;
    logic [7:0] alu_a, alu_b, alu_sum;
    logic       alu_cin, alu_sub, alu_cout, alu_zero;

    ctr_exp_t ctr_sb[$];
    alu_exp_t alu_sb[$];
    int n_checks = 0;
    int n_errors = 0;

    alu_clock_counter dut (
        .clk(clk), .reset(reset), .halt(halt), .pc_inc(pc_inc), .pc_load(pc_load),
        .pc_in(pc_in), .pc_out(pc_out), .step_next(step_next), .step(step),
        .running(running), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_sub(alu_sub), .alu_sum(alu_sum), .alu_cout(alu_cout), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of counter stimulus, queue the state expected after the edge.
    task automatic cycle(input logic rst_v, input logic hlt, input logic inc, input logic ld,
                         input logic [7:0] pin, input logic nxt,
                         input logic [7:0] e_pc, input logic [3:0] e_step, input logic e_run,
                         input string tag);
        ctr_exp_t e;
        reset = rst_v; halt = hlt; pc_inc = inc; pc_load = ld; pc_in = pin; step_next = nxt;
        ctr_sb.push_back('{pc: e_pc, step: e_step, run: e_run});
        @(posedge clk);
        #1;
        if (ctr_sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = ctr_sb.pop_front();
            check_eq({tag, "_pc"}, 16'(pc_out), 16'(e.pc));
            check_eq({tag, "_step"}, 16'(step), 16'(e.step));
            check_eq({tag, "_run"}, 16'(running), 16'(e.run));
        end
    endtask

    task automatic alu_case(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic sub, input logic [7:0] e_sum, input logic e_cout,
                            input logic e_zero, input string tag);
        alu_exp_t e;
        alu_a = a; alu_b = b; alu_cin = cin; alu_sub = sub;
        alu_sb.push_back('{sum: e_sum, cout: e_cout, zero: e_zero});
        #1;
        e = alu_sb.pop_front();
        check_eq({tag, "_sum"}, 16'(alu_sum), 16'(e.sum));
        check_eq({tag, "_cout"}, 16'(alu_cout), 16'(e.cout));
        check_eq({tag, "_zero"}, 16'(alu_zero), 16'(e.zero));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, rs;
        logic       rc, rsub, rco;
        logic [8:0] wide;

        reset = 1'b0; halt = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; pc_in = 8'h00;
        step_next = 1'b0; alu_a = 8'h00; alu_b = 8'h00; alu_cin = 1'b0; alu_sub = 1'b0;
        #2;

        // Reset, then increment 5 cycles.
        cycle(0, 0, 1, 0, 8'h00, 0, 8'h00, 4'd0, 1, "reset");
        for (int i = 1; i <= 5; i++)
            cycle(1, 0, 1, 0, 8'h00, 0, 8'(i), 4'(i), 1, "inc");

        // PC wrap from FE.
        cycle(1, 0, 0, 1, 8'hFE, 0, 8'hFE, 4'd6, 1, "load_fe");
        cycle(1, 0, 1, 0, 8'h00, 0, 8'hFF, 4'd7, 1, "wrap_ff");
        cycle(1, 0, 1, 0, 8'h00, 0, 8'h00, 4'd8, 1, "wrap_00");
        cycle(1, 0, 1, 0, 8'h00, 0, 8'h01, 4'd9, 1, "wrap_01");

        // Step wrap: clear then 17 free-running cycles -> 1..15, 0, 1.
        cycle(1, 0, 0, 0, 8'h00, 1, 8'h01, 4'd0, 1, "step_clr");
        for (int i = 1; i <= 17; i++)
            cycle(1, 0, 0, 0, 8'h00, 0, 8'h01, 4'(i), 1, "step_run");

        // Load beats increment; NEXT at step 3 clears then counting resumes.
        cycle(1, 0, 1, 1, 8'h3C, 0, 8'h3C, 4'd2, 1, "load_prio");
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h3C, 4'd3, 1, "to_step3");
        cycle(1, 0, 0, 0, 8'h00, 1, 8'h3C, 4'd0, 1, "next_clr");
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h3C, 4'd1, 1, "resume1");
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h3C, 4'd2, 1, "resume2");

        // Load and NEXT together both take effect.
        cycle(1, 0, 0, 1, 8'h07, 1, 8'h07, 4'd0, 1, "load_next");
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h07, 4'd1, 1, "pre_halt1");
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h07, 4'd2, 1, "pre_halt2");

        // Halt freezes everything; only reset restarts.
        cycle(1, 1, 1, 0, 8'h00, 0, 8'h07, 4'd2, 0, "halt");
        for (int i = 0; i < 10; i++)
            cycle(1, i[0], 1, i[1], 8'hAA, i[2], 8'h07, 4'd2, 0, "halted");
        cycle(0, 0, 1, 1, 8'h55, 0, 8'h00, 4'd0, 1, "restart");
        cycle(1, 0, 1, 0, 8'h00, 0, 8'h01, 4'd1, 1, "post_rst");

        // Reset beats halt and load in the same edge.
        cycle(1, 0, 1, 0, 8'h00, 0, 8'h02, 4'd2, 1, "pre_mid");
        cycle(0, 1, 1, 1, 8'h99, 1, 8'h00, 4'd0, 1, "rst_mid");
        cycle(1, 0, 0, 0, 8'h00, 0, 8'h00, 4'd1, 1, "rst_mid_run");

        // Directed ALU cases.
        alu_case(8'h0F, 8'h01, 0, 0, 8'h10, 0, 0, "add_0f_01");
        alu_case(8'hFF, 8'h01, 0, 0, 8'h00, 1, 1, "add_ff_01");
        alu_case(8'hFF, 8'h00, 1, 0, 8'h00, 1, 1, "add_ff_00_c");
        alu_case(8'h05, 8'h03, 0, 1, 8'h02, 1, 0, "sub_05_03");
        alu_case(8'h03, 8'h05, 0, 1, 8'hFE, 0, 0, "sub_03_05");
        alu_case(8'h42, 8'h42, 0, 1, 8'h00, 1, 1, "sub_42_42");
        alu_case(8'h05, 8'h03, 1, 1, 8'h02, 1, 0, "sub_cin_05_03");
        alu_case(8'h03, 8'h05, 1, 1, 8'hFE, 0, 0, "sub_cin_03_05");
        alu_case(8'h42, 8'h42, 1, 1, 8'h00, 1, 1, "sub_cin_42_42");

        // Random ALU cases against an arithmetic reference.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));   rsub = 1'($urandom_range(1));
            if (rsub) begin
                rs  = ra - rb;
                rco = (ra >= rb);
            end else begin
                wide = 9'(ra) + 9'(rb) + 9'(rc);
                rs   = wide[7:0];
                rco  = wide[8];
            end
            alu_case(ra, rb, rc, rsub, rs, rco, (rs == 8'h00), "alu_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
